// File: rtl/config_loader.sv
// Configuration chain controller: serialises host words onto the fabric config
// chain (LSB first) and reads them back non-destructively by recirculating the chain.
module config_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 16
) (
  input  logic                  config_clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_readback,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  chain_out,
  output logic                  chain_in,
  output logic                  chain_en,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  // Handshakes: a word moves on any edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.
  localparam int NW = (CHAIN_LENGTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int LB = CHAIN_LENGTH - (NW - 1) * DATA_WIDTH;
  localparam int TW = $clog2(CHAIN_LENGTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] LAST_BASE = TW'((NW - 1) * DATA_WIDTH);
  localparam logic [TW-1:0] TOTAL     = TW'(CHAIN_LENGTH);
  localparam logic [BW-1:0] WORD_MAX  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_MAX  = BW'(LB - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_WAIT  = 3'd1,
    LD_SHIFT = 3'd2,
    RB_SHIFT = 3'd3,
    RB_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [BW-1:0]         bit_cnt;
  logic [TW-1:0]         total_cnt;
  logic [DATA_WIDTH-1:0] shift_buf;
  logic [DATA_WIDTH-1:0] cap_reg;
  logic                  last_word;
  logic                  word_end;

  // The last word is the one whose first bit sits at or beyond LAST_BASE.
  assign last_word = (total_cnt >= LAST_BASE);
  assign word_end  = (bit_cnt == (last_word ? LAST_MAX : WORD_MAX));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_load)          state_next = LD_WAIT;
        else if (start_readback) state_next = RB_SHIFT;
      end
      LD_WAIT:  if (wr_valid) state_next = LD_SHIFT;
      LD_SHIFT: if (word_end) state_next = last_word ? DONE : LD_WAIT;
      RB_SHIFT: if (word_end) state_next = RB_HOLD;
      RB_HOLD:  if (rd_ready) state_next = (total_cnt == TOTAL) ? DONE : RB_SHIFT;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge config_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      total_cnt <= '0;
      shift_buf <= '0;
      cap_reg   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          bit_cnt   <= '0;
          total_cnt <= '0;
        end
        LD_WAIT: begin
          if (wr_valid) begin
            shift_buf <= wr_data;
            bit_cnt   <= '0;
          end
        end
        LD_SHIFT: begin
          shift_buf <= shift_buf >> 1;
          total_cnt <= total_cnt + TW'(1);
          bit_cnt   <= word_end ? '0 : bit_cnt + BW'(1);
        end
        RB_SHIFT: begin
          // First bit of a word clears the capture so unused upper bits read 0.
          if (bit_cnt == '0) cap_reg <= DATA_WIDTH'(chain_out);
          else               cap_reg[bit_cnt] <= chain_out;
          total_cnt <= total_cnt + TW'(1);
          bit_cnt   <= word_end ? '0 : bit_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_ready  = (state == LD_WAIT);
  assign rd_valid  = (state == RB_HOLD);
  assign rd_data   = cap_reg;
  assign chain_en  = (state == LD_SHIFT) || (state == RB_SHIFT);
  assign chain_in  = (state == LD_SHIFT) ? shift_buf[0] :
                     (state == RB_SHIFT) ? chain_out : 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (16-bit and 12-bit chains) each driving a
// behavioural shift chain; results are compared against a word-level bitstream model.
module tb_config_loader;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- host-side stimulus (sel picks the active instance) ----------------
  logic          sel = 1'b0;
  logic          start_load = 1'b0, start_readback = 1'b0;
  logic          wr_valid = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic          wr_ready_a, rd_valid_a, chain_in_a, chain_en_a, busy_a, done_a, chain_out_a;
  logic          wr_ready_b, rd_valid_b, chain_in_b, chain_en_b, busy_b, done_b, chain_out_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [2:0]    state_a, state_b;

  // Behavioural chains: bit k of the vector holds the k-th bit shifted in.
  logic [15:0] chain_a = 16'h0;
  logic [11:0] chain_b = 12'h0;
  assign chain_out_a = chain_a[0];
  assign chain_out_b = chain_b[0];
  always @(posedge clk) if (chain_en_a) chain_a <= {chain_in_a, chain_a[15:1]};
  always @(posedge clk) if (chain_en_b) chain_b <= {chain_in_b, chain_b[11:1]};

  config_loader #(.DATA_WIDTH(DW), .CHAIN_LENGTH(16)) u_a (
    .config_clk(clk), .reset(reset),
    .start_load(start_load & ~sel), .start_readback(start_readback & ~sel),
    .wr_data(wr_data), .wr_valid(wr_valid & ~sel), .wr_ready(wr_ready_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready & ~sel),
    .chain_out(chain_out_a), .chain_in(chain_in_a), .chain_en(chain_en_a),
    .busy(busy_a), .done(done_a), .state_dbg(state_a)
  );

  config_loader #(.DATA_WIDTH(DW), .CHAIN_LENGTH(12)) u_b (
    .config_clk(clk), .reset(reset),
    .start_load(start_load & sel), .start_readback(start_readback & sel),
    .wr_data(wr_data), .wr_valid(wr_valid & sel), .wr_ready(wr_ready_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready & sel),
    .chain_out(chain_out_b), .chain_in(chain_in_b), .chain_en(chain_en_b),
    .busy(busy_b), .done(done_b), .state_dbg(state_b)
  );

  logic          wr_ready, rd_valid, chain_in, chain_en, busy, done;
  logic [DW-1:0] rd_data;
  logic [2:0]    state_m;
  assign wr_ready = sel ? wr_ready_b : wr_ready_a;
  assign rd_valid = sel ? rd_valid_b : rd_valid_a;
  assign rd_data  = sel ? rd_data_b  : rd_data_a;
  assign chain_in = sel ? chain_in_b : chain_in_a;
  assign chain_en = sel ? chain_en_b : chain_en_a;
  assign busy     = sel ? busy_b     : busy_a;
  assign done     = sel ? done_b     : done_a;
  assign state_m  = sel ? state_b    : state_a;

  // ---------------- monitor ----------------
  logic bits_q[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   stall_err = 0;
  always @(negedge clk) begin
    if (chain_en) bits_q.push_back(chain_in);
    if (rd_valid && chain_en) stall_err++;
    if (!chain_en && chain_in) stall_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] load_q[$];
  logic [DW-1:0] exp_q[$];
  logic [63:0]   loaded_a = '0, loaded_b = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chain contents after a load: the words concatenated LSB-first, truncated to the chain.
  function automatic logic [63:0] ref_stream(input int cl);
    logic [63:0] s = '0;
    foreach (load_q[i]) s |= 64'(load_q[i]) << (i * DW);
    return s & ((64'd1 << cl) - 64'd1);
  endfunction

  function automatic logic [63:0] pack_bits();
    logic [63:0] v = '0;
    foreach (bits_q[i]) if (i < 64) v[i] = bits_q[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit use_b, input int gap_max, input bit both, input bit mid_rb);
    int cl, nw, k, g, t0, n0;
    logic [63:0] s;
    cl = use_b ? 12 : 16;
    nw = (cl + DW - 1) / DW;
    sel = use_b;
    n0 = done_cnt;
    bits_q.delete();
    start_load = 1'b1;
    start_readback = both;
    tick();
    start_load = 1'b0;
    start_readback = 1'b0;
    t0 = cyc;
    check("ld_wr_ready_rise", wr_ready, 1);
    check("ld_busy_rise", busy, 1);
    foreach (load_q[i]) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        wr_valid = 1'b0;
        repeat (g) tick();
      end
      wr_data = load_q[i];
      wr_valid = 1'b1;
      k = 0;
      while (!wr_ready && k < 200) begin
        tick();
        k++;
      end
      check("ld_wr_ready_timeout", k < 200, 1);
      tick();
      if (mid_rb && i == 0) begin
        start_readback = 1'b1;
        tick();
        start_readback = 1'b0;
      end
    end
    wr_valid = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check("ld_done_timeout", k < 200, 1);
    // With wr_valid held high, done is visible in cycle CHAIN_LENGTH+NW+1 after the start edge.
    if (gap_max == 0 && !mid_rb) check("ld_done_latency", cyc - t0, cl + nw);
    tick();
    check("ld_busy_fall", busy, 0);
    check("ld_done_once", done_cnt - n0, 1);
    s = ref_stream(cl);
    check("ld_shift_count", bits_q.size(), cl);
    check("ld_stream", pack_bits(), s);
    check("ld_chain_model", use_b ? 64'(chain_b) : 64'(chain_a), s);
    if (use_b) loaded_b = s;
    else       loaded_a = s;
  endtask

  task automatic run_readback(input bit use_b, input int stall);
    int cl, nw, k, n0;
    bit ok;
    logic [DW-1:0] hold;
    logic [63:0] s;
    cl = use_b ? 12 : 16;
    nw = (cl + DW - 1) / DW;
    s = use_b ? loaded_b : loaded_a;
    exp_q.delete();
    for (int i = 0; i < nw; i++) exp_q.push_back(DW'(s >> (i * DW)));
    sel = use_b;
    n0 = done_cnt;
    bits_q.delete();
    rd_ready = (stall == 0);
    start_readback = 1'b1;
    tick();
    start_readback = 1'b0;
    for (int i = 0; i < nw; i++) begin
      k = 0;
      while (!rd_valid && k < 200) begin
        tick();
        k++;
      end
      check("rb_valid_timeout", k < 200, 1);
      if (stall > 0) begin
        hold = rd_data;
        ok = 1'b1;
        repeat (stall) begin
          tick();
          if (!rd_valid || rd_data !== hold || chain_en) ok = 1'b0;
        end
        check("rb_stall_hold", ok, 1);
        rd_ready = 1'b1;
      end
      check("rb_word", rd_data, exp_q.pop_front());
      tick();
      if (stall > 0) rd_ready = 1'b0;
    end
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check("rb_done_timeout", k < 200, 1);
    tick();
    rd_ready = 1'b0;
    check("rb_done_once", done_cnt - n0, 1);
    check("rb_busy_fall", busy, 0);
    check("rb_shift_count", bits_q.size(), cl);
    check("rb_chain_restored", use_b ? 64'(chain_b) : 64'(chain_a), s);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    repeat (2) tick();
    sel = 1'b0;
    check("reset_outputs_a", {wr_ready, rd_valid, rd_data, chain_en, chain_in, busy, done}, 0);
    check("reset_state_a", state_m, 0);
    sel = 1'b1;
    #1;
    check("reset_outputs_b", {wr_ready, rd_valid, rd_data, chain_en, chain_in, busy, done}, 0);
    sel = 1'b0;
    reset = 1'b0;
    tick();

    // Known bitstream on the 16-bit chain, then straight readback.
    load_q = '{8'hA5, 8'h3C};
    run_load(1'b0, 0, 1'b0, 1'b0);
    check("ld_a5_3c_stream", pack_bits(), 64'h3CA5);
    run_readback(1'b0, 0);

    // 12-bit chain: only the low nibble of the second word is shifted.
    load_q = '{8'hFF, 8'h3C};
    run_load(1'b1, 0, 1'b0, 1'b0);
    check("ld12_last4", {bits_q[8], bits_q[9], bits_q[10], bits_q[11]}, 4'b0011);
    run_readback(1'b1, 0);

    // Host stalls five cycles on every readback word.
    load_q = '{DW'($urandom), DW'($urandom)};
    run_load(1'b0, 2, 1'b0, 1'b0);
    run_readback(1'b0, 5);

    // Simultaneous starts favour the load; a readback pulse mid-load is ignored.
    load_q = '{DW'($urandom), DW'($urandom)};
    run_load(1'b0, 0, 1'b1, 1'b1);

    // Reset during the third shift cycle of the first word.
    sel = 1'b0;
    n0 = done_cnt;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    wr_data = 8'h5A;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("rst_pre_shifting", chain_en, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_chain_en", chain_en, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_done", done_cnt - n0, 0);
    load_q = '{DW'($urandom), DW'($urandom)};
    run_load(1'b0, 0, 1'b0, 1'b0);
    run_readback(1'b0, 0);

    // Randomised loads and readbacks across both chain lengths.
    for (int it = 0; it < 6; it++) begin
      bit ub;
      ub = 1'($urandom_range(0, 1));
      load_q = '{DW'($urandom), DW'($urandom)};
      run_load(ub, 3, 1'b0, 1'b0);
      run_readback(ub, $urandom_range(0, 3));
    end

    check("no_shift_when_stalled", stall_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/config_loader.md
# config_loader

Bitstream controller for the configuration shift chain formed by daisy-chained config memories (IO blocks, logic blocks, switch boxes). Accepts parallel configuration words from a host over a valid/ready port, serialises them onto the chain's serial input with the chain enable, and signals completion. Also performs a non-destructive readback: it recirculates the chain through itself and returns the captured words to the host. It sits between the host/bitstream interface and the first `config_in` of the fabric chain, and receives the last `config_out`.

## Interface
- `DATA_WIDTH`, 8: host word width in bits (≥2).
- `CHAIN_LENGTH`, 16: total bits in the configuration chain (≥1). The default equals the chain of one 8-wide IO block.
- `config_clk` input 1: the single clock. Drives the loader and the chain.
- `reset` input 1: asynchronous, active-high reset.
- `start_load` input 1: pulse that begins a load. Sampled in IDLE only.
- `start_readback` input 1: pulse that begins a readback. Sampled in IDLE only.
- `wr_data` input DATA_WIDTH: configuration word, LSB shifted first.
- `wr_valid` input 1: wr_data is valid.
- `wr_ready` output 1: loader accepts wr_data this cycle.
- `rd_data` output DATA_WIDTH: readback word, LSB is the earliest captured bit.
- `rd_valid` output 1: rd_data is valid.
- `rd_ready` input 1: host accepts rd_data.
- `chain_out` input 1: the serial output of the last element in the chain.
- `chain_in` output 1: drives the first element's `config_in`.
- `chain_en` output 1: drives every element's `config_en`. When high, the chain shifts one bit at the next `config_clk` edge.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle pulse when a load or readback completes.

## Operation
- States: IDLE, LD_WAIT, LD_SHIFT, RB_SHIFT, RB_HOLD, DONE.
- Word count: NW = ceil(CHAIN_LENGTH/DATA_WIDTH).
- Last-word bit count: LB = CHAIN_LENGTH − (NW−1)·DATA_WIDTH.
- Counters:
  - `bit_cnt`: counts bits within the current word.
  - `total_cnt`: width clog2(CHAIN_LENGTH+1), cleared on entry to LD_WAIT or RB_SHIFT from IDLE.
- Starts:
  - IDLE with `start_load`=1 → LD_WAIT.
  - IDLE with only `start_readback`=1 → RB_SHIFT.
  - Both asserted together: load wins and readback is dropped.
  - Starts in any other state are ignored.
- Load:
  - LD_WAIT: `wr_ready`=1. When `wr_valid` & `wr_ready`, latch `wr_data` into the shift buffer and go to LD_SHIFT.
  - LD_SHIFT: `chain_en`=1, `chain_in`=buffer[0]. Each cycle the buffer shifts right, `bit_cnt` increments and `total_cnt` increments.
  - After DATA_WIDTH bits, or LB bits on the last word: go to LD_WAIT if `total_cnt` < CHAIN_LENGTH, else go to DONE.
  - Unused upper bits of the last word are never shifted.
- Readback:
  - RB_SHIFT: `chain_en`=1 and `chain_in`=`chain_out` (combinational recirculation). `chain_out` is shifted into the capture register at bit position `bit_cnt`.
  - On word completion (DATA_WIDTH bits, or LB for the last word) go to RB_HOLD. Capture bits above LB in the last word read as 0.
  - RB_HOLD: `chain_en`=0, `rd_valid`=1. On `rd_ready`, go to RB_SHIFT if `total_cnt` < CHAIN_LENGTH, else go to DONE.
  - After exactly CHAIN_LENGTH shifts the chain contents are restored.
  - Words return in the same order they were loaded.
- DONE: `done`=1 for one cycle, then IDLE.
- `chain_en` is 0 in IDLE, LD_WAIT, RB_HOLD and DONE. The chain never shifts while stalled on the host.
- `chain_in` is 0 whenever `chain_en`=0.

## Timing
- Reset values (applied asynchronously, immediately):
  - state IDLE; all counters 0.
  - `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `chain_en`=0, `chain_in`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from registered state, except `chain_in` during RB_SHIFT, which equals `chain_out` combinationally.
- `start_load` sampled at edge t: `wr_ready`=1 and `busy`=1 from cycle t+1.
- Word accepted at edge t: `chain_en`=1 for cycles t+1 … t+n, where n = DATA_WIDTH or LB. `wr_ready` returns at t+n+1, or `done` pulses at t+n+1.
- Minimum full-load time: CHAIN_LENGTH + NW + 1 cycles after the start edge, with `wr_valid` held high.
- Readback stall: `rd_valid` stays high and `rd_data` stays stable until `rd_ready`. The handshake completes on the edge where both are high.
- `wr_valid` deasserted in LD_WAIT: the loader waits indefinitely and `chain_en` stays 0.
- Reset mid-operation: the loader aborts to IDLE with no `done` pulse. Partially shifted chain contents are left as-is and are not cleared.

## Test plan
- Defaults, load 0xA5 then 0x3C with `wr_valid` held high → `chain_in` shows 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 `chain_en` cycles. `done` pulses once, 19 cycles after the start edge, and `busy` falls the next cycle.
- Defaults, behavioural 16-bit chain model preloaded by the previous test, start readback with `rd_ready`=1 → `rd_data` returns 0xA5 then 0x3C, and the model still holds the same 16 bits afterwards.
- CHAIN_LENGTH=12, load 0xFF then 0x3C → exactly 12 shifts, the last 4 being 0,0,1,1. Readback returns 0xFF then 0x0C.
- Readback with `rd_ready` low for 5 cycles after each `rd_valid` → `chain_en`=0 throughout every stall, `rd_data` stays constant, and the final data is correct.
- `start_load` and `start_readback` asserted together in IDLE → a load runs (`wr_ready` rises). A `start_readback` pulse mid-load has no effect.
- `reset` asserted on the third shift cycle of the first word → `chain_en`, `busy` and `wr_ready` go to 0 immediately and no `done` pulse occurs. A subsequent full load completes normally.
